// File: rtl/cache_evt_pkg.sv
// Shared types for the cache event arbiter: source encoding and the report record.
package cache_evt_pkg;

    localparam logic SRC_ICACHE = 1'b0;
    localparam logic SRC_DCACHE = 1'b1;

    typedef struct packed {
        logic src;
        logic miss;
    } evt_t;

endpackage

// File: rtl/cache_evt_fifo.sv
// Pointer-based event FIFO; a push into a full FIFO succeeds when a pop happens in the same cycle.
module cache_evt_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic [W-1:0] o_data,
    output logic         o_empty,
    output logic         o_drop
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]  r_wr_ptr;
    logic [AW:0]  r_rd_ptr;
    logic [W-1:0] r_mem [DEPTH];
    logic         w_full;
    logic         w_push_ok;
    logic         w_pop_ok;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_pop_ok  = i_pop & ~o_empty;
    assign w_push_ok = i_push & (~w_full | w_pop_ok);
    assign o_drop    = i_push & ~w_push_ok;
    assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

endmodule

// File: rtl/cache_evt_arbiter.sv
// Counts I/D-cache accesses and misses with saturation, and round-robin merges the
// buffered events onto one valid/ready report channel without ever stalling the caches.
module cache_evt_arbiter
    import cache_evt_pkg::*;
#(
    parameter int CNT_W      = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             icache_valid,
    input  logic             icache_miss,
    input  logic             dcache_valid,
    input  logic             dcache_miss,
    input  logic             freeze,
    input  logic             clear,
    output logic             rpt_valid,
    input  logic             rpt_ready,
    output logic             rpt_src,
    output logic             rpt_miss,
    output logic [CNT_W-1:0] icache_acc_cnt,
    output logic [CNT_W-1:0] icache_mis_cnt,
    output logic [CNT_W-1:0] dcache_acc_cnt,
    output logic [CNT_W-1:0] dcache_mis_cnt,
    output logic             drop_sticky
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != '1)) ? v + CNT_ONE : v;
    endfunction

    logic [CNT_W-1:0] r_ic_acc, r_ic_mis, r_dc_acc, r_dc_mis;
    logic             r_drop;
    logic             r_ptr;
    logic             r_rpt_valid;
    evt_t             r_rpt;

    logic w_i_evt, w_d_evt;
    logic w_i_data, w_d_data;
    logic w_i_empty, w_d_empty;
    logic w_i_drop, w_d_drop;
    logic w_i_pop, w_d_pop;
    logic w_load_en, w_any, w_contested, w_take;
    logic w_grant_src;

    assign w_i_evt = icache_valid & ~freeze;
    assign w_d_evt = dcache_valid & ~freeze;

    cache_evt_fifo #(.DEPTH(FIFO_DEPTH), .W(1)) u_ififo (
        .clk(clk), .rst_n(rst_n),
        .i_push(w_i_evt), .i_data(icache_miss), .i_pop(w_i_pop),
        .o_data(w_i_data), .o_empty(w_i_empty), .o_drop(w_i_drop)
    );

    cache_evt_fifo #(.DEPTH(FIFO_DEPTH), .W(1)) u_dfifo (
        .clk(clk), .rst_n(rst_n),
        .i_push(w_d_evt), .i_data(dcache_miss), .i_pop(w_d_pop),
        .o_data(w_d_data), .o_empty(w_d_empty), .o_drop(w_d_drop)
    );

    // The report register refills whenever it is empty or being consumed this cycle.
    assign w_load_en   = ~r_rpt_valid | rpt_ready;
    assign w_any       = ~w_i_empty | ~w_d_empty;
    assign w_contested = ~w_i_empty & ~w_d_empty;
    assign w_take      = w_load_en & w_any;

    always_comb begin
        w_grant_src = SRC_ICACHE;
        if (w_contested) w_grant_src = r_ptr;
        else if (!w_d_empty) w_grant_src = SRC_DCACHE;
    end

    assign w_i_pop = w_take & (w_grant_src == SRC_ICACHE);
    assign w_d_pop = w_take & (w_grant_src == SRC_DCACHE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rpt_valid <= 1'b0;
            r_rpt       <= '0;
            r_ptr       <= SRC_ICACHE;
        end else if (w_load_en) begin
            r_rpt_valid <= w_any;
            if (w_any) begin
                r_rpt.src  <= w_grant_src;
                r_rpt.miss <= (w_grant_src == SRC_DCACHE) ? w_d_data : w_i_data;
            end
            // Only a contested grant moves the pointer, to the source that lost.
            if (w_take && w_contested) r_ptr <= ~w_grant_src;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ic_acc <= '0;
            r_ic_mis <= '0;
            r_dc_acc <= '0;
            r_dc_mis <= '0;
            r_drop   <= 1'b0;
        end else if (clear) begin
            r_ic_acc <= '0;
            r_ic_mis <= '0;
            r_dc_acc <= '0;
            r_dc_mis <= '0;
            r_drop   <= 1'b0;
        end else begin
            r_ic_acc <= sat_inc(r_ic_acc, w_i_evt);
            r_ic_mis <= sat_inc(r_ic_mis, w_i_evt & icache_miss);
            r_dc_acc <= sat_inc(r_dc_acc, w_d_evt);
            r_dc_mis <= sat_inc(r_dc_mis, w_d_evt & dcache_miss);
            r_drop   <= r_drop | w_i_drop | w_d_drop;
        end
    end

    assign rpt_valid      = r_rpt_valid;
    assign rpt_src        = r_rpt.src;
    assign rpt_miss       = r_rpt.miss;
    assign icache_acc_cnt = r_ic_acc;
    assign icache_mis_cnt = r_ic_mis;
    assign dcache_acc_cnt = r_dc_acc;
    assign dcache_mis_cnt = r_dc_mis;
    assign drop_sticky    = r_drop;

endmodule

// File: tb/tb_cache_evt_arbiter.sv
// Directed bench for cache_evt_arbiter built with 4-bit counters so saturation is reachable.
module tb_cache_evt_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       icache_valid, icache_miss, dcache_valid, dcache_miss;
    logic       freeze, clear, rpt_ready;
    logic       rpt_valid, rpt_src, rpt_miss, drop_sticky;
    logic [3:0] icache_acc_cnt, icache_mis_cnt, dcache_acc_cnt, dcache_mis_cnt;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [1:0] exp_q[$];

    always #5 clk = ~clk;

    cache_evt_arbiter #(.CNT_W(4), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .icache_valid(icache_valid), .icache_miss(icache_miss),
        .dcache_valid(dcache_valid), .dcache_miss(dcache_miss),
        .freeze(freeze), .clear(clear),
        .rpt_valid(rpt_valid), .rpt_ready(rpt_ready),
        .rpt_src(rpt_src), .rpt_miss(rpt_miss),
        .icache_acc_cnt(icache_acc_cnt), .icache_mis_cnt(icache_mis_cnt),
        .dcache_acc_cnt(dcache_acc_cnt), .dcache_mis_cnt(dcache_mis_cnt),
        .drop_sticky(drop_sticky)
    );

    typedef struct {
        logic       iv, im, dv, dm, clr;
        logic       e_v, e_src, e_miss;
        logic [3:0] e_ia, e_im, e_da, e_dm;
    } vec_t;

    vec_t vecs[13];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_counts(input string tag, input logic [3:0] ia, input logic [3:0] im,
                              input logic [3:0] da, input logic [3:0] dm);
        chk({tag, " icache_acc"}, icache_acc_cnt, ia);
        chk({tag, " icache_mis"}, icache_mis_cnt, im);
        chk({tag, " dcache_acc"}, dcache_acc_cnt, da);
        chk({tag, " dcache_mis"}, dcache_mis_cnt, dm);
    endtask

    task automatic set_evt(input logic iv, input logic im, input logic dv, input logic dm);
        icache_valid = iv;
        icache_miss  = im;
        dcache_valid = dv;
        dcache_miss  = dm;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    // Consumes reports with rpt_ready held high; each sampled valid is one handshake.
    task automatic drain(input string tag, input int max_cycles);
        logic [1:0] exp;
        rpt_ready = 1'b1;
        for (int c = 0; c < max_cycles; c++) begin
            if (rpt_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL %s extra report: got src=%0d miss=%0d, expected none",
                             tag, rpt_src, rpt_miss);
                end else begin
                    exp = exp_q.pop_front();
                    chk({tag, " report {src,miss}"}, {rpt_src, rpt_miss}, exp);
                end
            end
            tick();
        end
        chk({tag, " reports missing"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        rst_n = 1'b0;
        set_evt(0, 0, 0, 0);
        freeze    = 1'b0;
        clear     = 1'b0;
        rpt_ready = 1'b1;

        // iv im dv dm clr | valid src miss | ia im da dm
        vecs[0]  = '{1, 1, 0, 0, 0, 1'b0, 1'b0, 1'b0, 4'd1, 4'd1, 4'd0, 4'd0};
        vecs[1]  = '{0, 0, 0, 0, 0, 1'b1, 1'b0, 1'b1, 4'd1, 4'd1, 4'd0, 4'd0};
        vecs[2]  = '{0, 0, 0, 0, 1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0};
        vecs[3]  = '{1, 0, 1, 1, 0, 1'b0, 1'b0, 1'b0, 4'd1, 4'd0, 4'd1, 4'd1};
        vecs[4]  = '{1, 1, 1, 0, 0, 1'b1, 1'b0, 1'b0, 4'd2, 4'd1, 4'd2, 4'd1};
        vecs[5]  = '{1, 0, 1, 0, 0, 1'b1, 1'b1, 1'b1, 4'd3, 4'd1, 4'd3, 4'd1};
        vecs[6]  = '{1, 0, 1, 1, 0, 1'b1, 1'b0, 1'b1, 4'd4, 4'd1, 4'd4, 4'd2};
        vecs[7]  = '{0, 0, 0, 0, 0, 1'b1, 1'b1, 1'b0, 4'd4, 4'd1, 4'd4, 4'd2};
        vecs[8]  = '{0, 0, 0, 0, 0, 1'b1, 1'b0, 1'b0, 4'd4, 4'd1, 4'd4, 4'd2};
        vecs[9]  = '{0, 0, 0, 0, 0, 1'b1, 1'b1, 1'b0, 4'd4, 4'd1, 4'd4, 4'd2};
        vecs[10] = '{0, 0, 0, 0, 0, 1'b1, 1'b0, 1'b0, 4'd4, 4'd1, 4'd4, 4'd2};
        vecs[11] = '{0, 0, 0, 0, 0, 1'b1, 1'b1, 1'b1, 4'd4, 4'd1, 4'd4, 4'd2};
        vecs[12] = '{0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 4'd4, 4'd1, 4'd4, 4'd2};

        // Reset state
        repeat (2) tick();
        chk("reset rpt_valid", rpt_valid, 0);
        chk("reset rpt_src", rpt_src, 0);
        chk("reset rpt_miss", rpt_miss, 0);
        chk("reset drop_sticky", drop_sticky, 0);
        chk_counts("reset", 0, 0, 0, 0);
        rst_n = 1'b1;
        tick();

        // Single-event latency, then both caches together alternating I,D,...
        for (int i = 0; i < 13; i++) begin
            set_evt(vecs[i].iv, vecs[i].im, vecs[i].dv, vecs[i].dm);
            clear = vecs[i].clr;
            tick();
            chk($sformatf("vec%0d rpt_valid", i), rpt_valid, vecs[i].e_v);
            if (vecs[i].e_v) begin
                chk($sformatf("vec%0d rpt_src", i), rpt_src, vecs[i].e_src);
                chk($sformatf("vec%0d rpt_miss", i), rpt_miss, vecs[i].e_miss);
            end
            chk_counts($sformatf("vec%0d", i), vecs[i].e_ia, vecs[i].e_im, vecs[i].e_da, vecs[i].e_dm);
            chk($sformatf("vec%0d drop_sticky", i), drop_sticky, 0);
        end
        set_evt(0, 0, 0, 0);
        clear = 1'b0;

        // Back-pressure: 6 D events, 1 held + 4 queued + 1 dropped
        do_clear();
        rpt_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            set_evt(0, 0, 1, (k == 0));
            tick();
            if (k >= 1) begin
                chk($sformatf("hold%0d rpt_valid", k), rpt_valid, 1);
                chk($sformatf("hold%0d rpt_src", k), rpt_src, 1);
                chk($sformatf("hold%0d rpt_miss", k), rpt_miss, 1);
            end
            chk($sformatf("hold%0d drop_sticky", k), drop_sticky, (k == 5));
        end
        set_evt(0, 0, 0, 0);
        chk_counts("backpressure", 0, 0, 6, 1);
        exp_q.push_back(2'b11);
        for (int k = 0; k < 4; k++) exp_q.push_back(2'b10);
        drain("backpressure drain", 10);
        chk("backpressure drop persists", drop_sticky, 1);

        // Saturation and clear priority
        do_clear();
        chk("clear drop_sticky", drop_sticky, 0);
        set_evt(1, 1, 0, 0);
        repeat (15) tick();
        chk("sat reach icache_acc", icache_acc_cnt, 15);
        chk("sat reach icache_mis", icache_mis_cnt, 15);
        tick();
        chk("sat hold icache_acc", icache_acc_cnt, 15);
        chk("sat hold icache_mis", icache_mis_cnt, 15);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        set_evt(0, 0, 0, 0);
        chk_counts("clear with access", 0, 0, 0, 0);
        repeat (3) tick();
        chk("sat drain rpt_valid", rpt_valid, 0);
        chk("sat drop_sticky", drop_sticky, 0);

        // freeze blocks counting/queueing but not draining
        do_clear();
        rpt_ready = 1'b0;
        set_evt(1, 1, 0, 0);
        tick();
        set_evt(1, 0, 0, 0);
        tick();
        freeze = 1'b1;
        for (int k = 0; k < 5; k++) begin
            set_evt(0, 0, 1, 1);
            tick();
        end
        set_evt(0, 0, 0, 0);
        chk_counts("freeze", 2, 1, 0, 0);
        chk("freeze held src", rpt_src, 0);
        exp_q.push_back(2'b01);
        exp_q.push_back(2'b00);
        drain("freeze drain", 8);
        chk_counts("freeze after drain", 2, 1, 0, 0);
        freeze = 1'b0;

        // Reset mid-stream with 3 events queued
        do_clear();
        rpt_ready = 1'b0;
        set_evt(1, 1, 0, 0);
        repeat (3) tick();
        set_evt(0, 0, 0, 0);
        chk("pre-reset rpt_valid", rpt_valid, 1);
        rst_n = 1'b0;
        #2;
        chk("async reset rpt_valid", rpt_valid, 0);
        tick();
        chk("reset mid rpt_valid", rpt_valid, 0);
        chk_counts("reset mid", 0, 0, 0, 0);
        rst_n = 1'b1;
        rpt_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("post-reset idle%0d rpt_valid", k), rpt_valid, 0);
        end

        // Pointer back to I-cache after reset
        set_evt(1, 0, 1, 1);
        tick();
        set_evt(0, 0, 0, 0);
        exp_q.push_back(2'b00);
        exp_q.push_back(2'b11);
        drain("post-reset order", 6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog");
    end

endmodule
